// File: rtl/inta_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : inta_sequencer
// Purpose  : CPU-side interrupt-acknowledge initiator for an 8259A PIC.
//            Watches the PIC INT request and, while interrupts are enabled,
//            drives the two-pulse active-low INTA sequence. The vector the
//            PIC places on the data bus during the second pulse is captured
//            and handed to the core over a valid/ready handshake.
// Ports    : clk          - single clock, rising-edge
//            reset        - asynchronous, active-high
//            INT          - PIC interrupt request (asynchronous to clk)
//            INT_EN       - core interrupt-enable flag
//            DATA_IN[7:0] - PIC data bus, vector valid during pulse 2
//            vector_ready - core accepts the vector
//            INTA         - interrupt acknowledge to PIC, active-low
//            LOCK         - bus lock across the whole two-pulse sequence
//            vector[7:0]  - last captured interrupt vector
//            vector_valid - vector holds a new, unconsumed value
//            busy         - sequencer is not idle
// Revision : 1.0 - initial release
// ============================================================================
module inta_sequencer #(
  parameter int PULSE_CYCLES   = 2,
  parameter int GAP_CYCLES     = 2,
  parameter int HOLDOFF_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       INT,
  input  logic       INT_EN,
  input  logic [7:0] DATA_IN,
  input  logic       vector_ready,
  output logic       INTA,
  output logic       LOCK,
  output logic [7:0] vector,
  output logic       vector_valid,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ACK1    = 3'd1,
    S_GAP     = 3'd2,
    S_ACK2    = 3'd3,
    S_DELIVER = 3'd4,
    S_HOLDOFF = 3'd5
  } state_t;

  // Counter reload values: a state that loads N-1 lasts exactly N cycles,
  // because it leaves on the edge where the counter is already zero.
  localparam logic [7:0] c_pulse_load = 8'(PULSE_CYCLES - 1);
  localparam logic [7:0] c_gap_load   = 8'(GAP_CYCLES - 1);
  localparam logic [7:0] c_hold_load  =
      (HOLDOFF_CYCLES > 0) ? 8'(HOLDOFF_CYCLES - 1) : 8'd0;

  state_t     r_state;
  logic [7:0] r_count;
  logic       r_int_meta;
  logic       r_int_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_count      <= 8'd0;
      r_int_meta   <= 1'b0;
      r_int_s      <= 1'b0;
      INTA         <= 1'b1;
      LOCK         <= 1'b0;
      vector       <= 8'h00;
      vector_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      // Two-flop synchronizer for the asynchronous PIC request.
      r_int_meta <= INT;
      r_int_s    <= r_int_meta;

      case (r_state)
        S_IDLE: begin
          // Entering ACK1 is the commit point: from here on neither INT
          // nor INT_EN can abort the sequence.
          if (r_int_s && INT_EN) begin
            r_state <= S_ACK1;
            r_count <= c_pulse_load;
            INTA    <= 1'b0;
            LOCK    <= 1'b1;
            busy    <= 1'b1;
          end
        end

        S_ACK1: begin
          if (r_count == 8'd0) begin
            r_state <= S_GAP;
            r_count <= c_gap_load;
            INTA    <= 1'b1;
          end else begin
            r_count <= r_count - 8'd1;
          end
        end

        S_GAP: begin
          if (r_count == 8'd0) begin
            r_state <= S_ACK2;
            r_count <= c_pulse_load;
            INTA    <= 1'b0;
          end else begin
            r_count <= r_count - 8'd1;
          end
        end

        S_ACK2: begin
          // The PIC drives the vector throughout pulse 2; sample it on the
          // edge that ends the pulse.
          if (r_count == 8'd0) begin
            r_state      <= S_DELIVER;
            vector       <= DATA_IN;
            vector_valid <= 1'b1;
            INTA         <= 1'b1;
            LOCK         <= 1'b0;
          end else begin
            r_count <= r_count - 8'd1;
          end
        end

        S_DELIVER: begin
          if (vector_valid && vector_ready) begin
            vector_valid <= 1'b0;
            if (HOLDOFF_CYCLES == 0) begin
              r_state <= S_IDLE;
              busy    <= 1'b0;
            end else begin
              r_state <= S_HOLDOFF;
              r_count <= c_hold_load;
            end
          end
        end

        S_HOLDOFF: begin
          // Gives the PIC time to drop INT before it is looked at again.
          if (r_count == 8'd0) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end else begin
            r_count <= r_count - 8'd1;
          end
        end

        default: begin
          r_state      <= S_IDLE;
          r_count      <= 8'd0;
          INTA         <= 1'b1;
          LOCK         <= 1'b0;
          vector_valid <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
